// File: rtl/cache_controller_if.sv
// Core-side request/lookup bundle and memory-side command bundle for cache_controller.
// The master is the core/cache-array side; the slave is the controller.
interface cache_controller_if #(
    parameter int TAG_W = 3,
    parameter int CNT_W = 32
);
    logic             req_valid;
    logic             req_write;
    logic [31:0]      req_addr;
    logic             hit;
    logic             victim_valid;
    logic             victim_dirty;
    logic [TAG_W-1:0] victim_tag;

    logic [31:0]      cache_addr;
    logic             cache_write_en;
    logic             fill_en;
    logic [31:0]      mem_addr;
    logic             mem_read_en;
    logic             mem_write_en;
    logic             stall;
    logic             done;
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] miss_count;

    modport master (
        output req_valid, req_write, req_addr, hit, victim_valid, victim_dirty, victim_tag,
        input  cache_addr, cache_write_en, fill_en, mem_addr, mem_read_en, mem_write_en,
               stall, done, hit_count, miss_count
    );

    modport slave (
        input  req_valid, req_write, req_addr, hit, victim_valid, victim_dirty, victim_tag,
        output cache_addr, cache_write_en, fill_en, mem_addr, mem_read_en, mem_write_en,
               stall, done, hit_count, miss_count
    );
endinterface

// File: rtl/cache_controller.sv
// Sequencer for a direct-mapped, write-back, one-word-line data cache in front of a
// fixed-latency main memory: zero-wait hits, write-back/fill on misses, hit/miss counters.
module cache_controller #(
    parameter int INDEX_W     = 11,
    parameter int ADDR_W      = 16,
    parameter int TAG_W       = ADDR_W - INDEX_W - 2,
    parameter int MEM_LATENCY = 4,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               rst_b,
    cache_controller_if.slave  bus
);
    localparam int CYC_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(MEM_LATENCY - 1);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WRITEBACK = 2'd1;
    localparam logic [1:0] S_FILL      = 2'd2;
    localparam logic [1:0] S_RESPOND   = 2'd3;

    logic [1:0]       r_state;
    logic [CYC_W-1:0] r_cyc;
    logic [31:0]      r_addr;
    logic             r_write;
    logic [TAG_W-1:0] r_victim_tag;
    logic [CNT_W-1:0] r_hit_count;
    logic [CNT_W-1:0] r_miss_count;

    logic             w_idle;
    logic             w_idle_hit;
    logic             w_idle_miss;
    logic             w_last;
    logic [ADDR_W-1:0] w_wb_addr;

    assign w_idle      = (r_state == S_IDLE);
    assign w_idle_hit  = w_idle && bus.req_valid && bus.hit;
    assign w_idle_miss = w_idle && bus.req_valid && !bus.hit;
    assign w_last      = (r_cyc == LAST_CYC);
    assign w_wb_addr   = {r_victim_tag, r_addr[INDEX_W+1:2], 2'b00};

    // NOTE: every register here uses <= so all state updates see pre-edge values.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state      <= S_IDLE;
            r_cyc        <= '0;
            r_addr       <= '0;
            r_write      <= 1'b0;
            r_victim_tag <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_idle_miss) begin
                        r_addr       <= bus.req_addr;
                        r_write      <= bus.req_write;
                        r_victim_tag <= bus.victim_tag;
                        r_cyc        <= '0;
                        r_state      <= (bus.victim_valid && bus.victim_dirty) ? S_WRITEBACK : S_FILL;
                    end
                end
                S_WRITEBACK: begin
                    if (w_last) begin
                        r_cyc   <= '0;
                        r_state <= S_FILL;
                    end else begin
                        r_cyc <= r_cyc + CYC_W'(1);
                    end
                end
                S_FILL: begin
                    if (w_last) begin
                        r_cyc   <= '0;
                        r_state <= S_RESPOND;
                    end else begin
                        r_cyc <= r_cyc + CYC_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Counters saturate at all-ones; the RESPOND completion is not a hit.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_idle_hit && (r_hit_count != '1))
                r_hit_count <= r_hit_count + CNT_W'(1);
            if (w_idle_miss && (r_miss_count != '1))
                r_miss_count <= r_miss_count + CNT_W'(1);
        end
    end

    logic        w_stall;
    logic        w_done;
    logic        w_cache_write_en;
    logic        w_fill_en;
    logic        w_mem_read_en;
    logic        w_mem_write_en;
    logic [31:0] w_mem_addr;

    // NOTE: defaults first so no path through this block can infer a latch.
    always_comb begin
        w_stall          = 1'b0;
        w_done           = 1'b0;
        w_cache_write_en = 1'b0;
        w_fill_en        = 1'b0;
        w_mem_read_en    = 1'b0;
        w_mem_write_en   = 1'b0;
        w_mem_addr       = '0;
        case (r_state)
            S_IDLE: begin
                if (w_idle_hit) begin
                    w_done           = 1'b1;
                    w_cache_write_en = bus.req_write;
                end else if (w_idle_miss) begin
                    w_stall = 1'b1;
                end
            end
            S_WRITEBACK: begin
                w_stall        = 1'b1;
                w_mem_write_en = 1'b1;
                w_mem_addr     = 32'(w_wb_addr);
            end
            S_FILL: begin
                w_stall       = 1'b1;
                w_mem_read_en = 1'b1;
                w_fill_en     = w_last;
                w_mem_addr    = {r_addr[31:2], 2'b00};
            end
            default: begin
                w_done           = 1'b1;
                w_cache_write_en = r_write;
            end
        endcase
    end

    // Gate with reset so a pending request cannot raise stall/done while held in reset.
    assign bus.stall          = w_stall          & rst_b;
    assign bus.done           = w_done           & rst_b;
    assign bus.cache_write_en = w_cache_write_en & rst_b;
    assign bus.fill_en        = w_fill_en        & rst_b;
    assign bus.mem_read_en    = w_mem_read_en    & rst_b;
    assign bus.mem_write_en   = w_mem_write_en   & rst_b;
    assign bus.mem_addr       = w_mem_addr;
    assign bus.cache_addr     = w_idle ? bus.req_addr : r_addr;
    assign bus.hit_count      = r_hit_count;
    assign bus.miss_count     = r_miss_count;
endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: hit/miss latencies, write-back addressing,
// input isolation after a miss, mid-fill reset and counter saturation.
module tb_cache_controller;
    logic clk;
    logic rst_b;
    int   checks;
    int   errors;

    cache_controller_if #(.TAG_W(3), .CNT_W(32)) bus ();
    cache_controller_if #(.TAG_W(3), .CNT_W(4))  sbus ();

    cache_controller dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    cache_controller #(.CNT_W(4)) dut_sat (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (sbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Flag order: {stall, done, mem_read_en, mem_write_en, fill_en, cache_write_en}
    function automatic logic [5:0] flags();
        return {bus.stall, bus.done, bus.mem_read_en, bus.mem_write_en, bus.fill_en, bus.cache_write_en};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [5:0] exp_f, input logic [31:0] exp_ma);
        @(negedge clk);
        chk($sformatf("%s.flags", tag), 64'(flags()), 64'(exp_f));
        chk($sformatf("%s.mem_addr", tag), 64'(bus.mem_addr), 64'(exp_ma));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_b  = 1'b0;
        bus.req_valid = 0;  bus.req_write = 0;  bus.req_addr = '0;  bus.hit = 0;
        bus.victim_valid = 0;  bus.victim_dirty = 0;  bus.victim_tag = '0;
        sbus.req_valid = 0; sbus.req_write = 0; sbus.req_addr = '0; sbus.hit = 0;
        sbus.victim_valid = 0; sbus.victim_dirty = 0; sbus.victim_tag = '0;

        cyc("reset", 6'b000000, 32'h0);
        chk("reset.hit_count", 64'(bus.hit_count), 64'd0);
        chk("reset.miss_count", 64'(bus.miss_count), 64'd0);
        tick();
        rst_b = 1'b1;

        // Cold load miss at 0x40: done in cycle 5
        bus.req_valid = 1; bus.req_write = 0; bus.req_addr = 32'h40; bus.hit = 0;
        cyc("ld40.c0", 6'b100000, 32'h0);
        chk("ld40.cache_addr", 64'(bus.cache_addr), 64'h40);
        tick();
        for (int i = 1; i <= 3; i++) begin
            cyc("ld40.fill", 6'b101000, 32'h40); tick();
        end
        cyc("ld40.c4", 6'b101010, 32'h40); tick();
        cyc("ld40.c5", 6'b010000, 32'h0);  tick();
        bus.req_valid = 0;
        cyc("idle1", 6'b000000, 32'h0);
        chk("ld40.miss_count", 64'(bus.miss_count), 64'd1);
        chk("ld40.hit_count", 64'(bus.hit_count), 64'd0);
        tick();

        // Load hit
        bus.req_valid = 1; bus.hit = 1;
        cyc("ldhit", 6'b010000, 32'h0); tick();
        bus.req_valid = 0; bus.hit = 0;
        cyc("idle2", 6'b000000, 32'h0);
        chk("ldhit.hit_count", 64'(bus.hit_count), 64'd1);
        tick();

        // Store hit
        bus.req_valid = 1; bus.req_write = 1; bus.hit = 1;
        cyc("sthit", 6'b010001, 32'h0); tick();
        bus.req_valid = 0; bus.req_write = 0; bus.hit = 0;
        cyc("idle3", 6'b000000, 32'h0);
        chk("sthit.hit_count", 64'(bus.hit_count), 64'd2);
        tick();

        // Dirty miss at 0x2040 evicting tag 0: write-back 0x40, fill 0x2040, done in cycle 9
        bus.req_valid = 1; bus.req_addr = 32'h2040; bus.victim_valid = 1; bus.victim_dirty = 1; bus.victim_tag = 3'd0;
        cyc("dm.c0", 6'b100000, 32'h0); tick();
        bus.victim_tag = 3'd5; bus.victim_dirty = 0;
        for (int i = 1; i <= 4; i++) begin
            cyc("dm.wb", 6'b100100, 32'h40); tick();
        end
        for (int i = 5; i <= 7; i++) begin
            cyc("dm.fill", 6'b101000, 32'h2040); tick();
        end
        cyc("dm.c8", 6'b101010, 32'h2040); tick();
        cyc("dm.c9", 6'b010000, 32'h0);    tick();
        bus.req_valid = 0;
        cyc("idle4", 6'b000000, 32'h0);
        chk("dm.miss_count", 64'(bus.miss_count), 64'd2);
        tick();

        // Store miss to clean line at 0x80; request inputs change mid-fill
        bus.req_valid = 1; bus.req_write = 1; bus.req_addr = 32'h80;
        bus.victim_valid = 1; bus.victim_dirty = 0; bus.victim_tag = 3'd2;
        cyc("sm.c0", 6'b100000, 32'h0);  tick();
        cyc("sm.c1", 6'b101000, 32'h80); tick();
        bus.req_addr = 32'h1234; bus.req_write = 0;
        cyc("sm.c2", 6'b101000, 32'h80);
        chk("sm.cache_addr", 64'(bus.cache_addr), 64'h80);
        tick();
        cyc("sm.c3", 6'b101000, 32'h80); tick();
        cyc("sm.c4", 6'b101010, 32'h80); tick();
        cyc("sm.c5", 6'b010001, 32'h0);  tick();
        bus.req_valid = 0;
        cyc("idle5", 6'b000000, 32'h0);
        chk("sm.miss_count", 64'(bus.miss_count), 64'd3);
        tick();

        // Reset in the second FILL cycle, then the same load re-runs from scratch
        bus.req_valid = 1; bus.req_write = 0; bus.req_addr = 32'h100; bus.victim_valid = 0;
        cyc("rs.c0", 6'b100000, 32'h0);   tick();
        cyc("rs.c1", 6'b101000, 32'h100); tick();
        rst_b = 1'b0;
        #1;
        chk("rs.flags", 64'(flags()), 64'd0);
        chk("rs.mem_addr", 64'(bus.mem_addr), 64'd0);
        chk("rs.hit_count", 64'(bus.hit_count), 64'd0);
        chk("rs.miss_count", 64'(bus.miss_count), 64'd0);
        #1;
        rst_b = 1'b1;
        cyc("rr.c0", 6'b100000, 32'h0); tick();
        for (int i = 1; i <= 3; i++) begin
            cyc("rr.fill", 6'b101000, 32'h100); tick();
        end
        cyc("rr.c4", 6'b101010, 32'h100); tick();
        cyc("rr.c5", 6'b010000, 32'h0);   tick();
        bus.req_valid = 0;
        cyc("idle6", 6'b000000, 32'h0);
        chk("rr.miss_count", 64'(bus.miss_count), 64'd1);
        tick();

        // 4-bit hit counter saturation
        sbus.req_valid = 1; sbus.hit = 1;
        repeat (14) tick();
        chk("sat.hit14", 64'(sbus.hit_count), 64'd14);
        chk("sat.done", 64'(sbus.done), 64'd1);
        tick();
        chk("sat.hit15", 64'(sbus.hit_count), 64'hF);
        repeat (3) tick();
        chk("sat.hold", 64'(sbus.hit_count), 64'hF);
        chk("sat.miss", 64'(sbus.miss_count), 64'd0);
        sbus.req_valid = 0; sbus.hit = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
